// File: rtl/inout_bus_ctrl_pkg.sv
// Shared definitions for the half-duplex bus controller: FSM state encodings
// and the turnaround counter width.
package inout_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } bus_state_e;

  localparam int CNT_W    = 4;
  localparam int TURN_MAX = (1 << CNT_W) - 1;

endpackage : inout_bus_ctrl_pkg

// File: rtl/inout_bus_ctrl_tristate_buf.sv
// Tri-state driver and input path for the shared bus, kept separate so it can
// be replaced by pad primitives without touching the controller.
module inout_tristate_buf #(
  parameter int width = 1
) (
  inout  wire  [width-1:0] IO,
  input  logic             oe_i,
  input  logic [width-1:0] out_i,
  output logic [width-1:0] in_o
);

  assign IO   = oe_i ? out_i : {width{1'bz}};
  assign in_o = IO;

endmodule : inout_tristate_buf

// File: rtl/inout_bus_ctrl.sv
// Half-duplex bus controller: arbitrates local transmit against receive
// sampling and inserts high-Z turnaround gaps on every direction change.
module inout_bus_ctrl
  import inout_bus_ctrl_pkg::*;
#(
  parameter int width       = 1,
  parameter int turn_cycles = 2
) (
  input  logic             CLK,
  input  logic             RST,
  inout  wire  [width-1:0] IO,
  input  logic [width-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             rd_valid,
  output logic             bus_dir
);

  if ((turn_cycles < 0) || (turn_cycles > TURN_MAX)) begin : g_turn_cycles_range
    $error("inout_bus_ctrl: turn_cycles=%0d outside 0..%0d", turn_cycles, TURN_MAX);
  end

  // Counter preload; a dwell of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] TURN_LOAD =
    (turn_cycles == 0) ? '0 : CNT_W'(turn_cycles - 1);

  bus_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   oe_q;
  logic [width-1:0]       out_q;
  logic [width-1:0]       rd_data_q;
  logic                   rd_valid_q;
  logic                   tx_ready_q;
  logic [width-1:0]       io_in;

  inout_tristate_buf #(.width(width)) u_tristate_buf (
    .IO    (IO),
    .oe_i  (oe_q),
    .out_i (out_q),
    .in_o  (io_in)
  );

  // Controller FSM, turnaround counter and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RX;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      out_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_RX: begin
          oe_q <= 1'b0;
          if (rd_en) begin
            rd_data_q  <= io_in;
            rd_valid_q <= 1'b1;
          end
          if (tx_valid) begin
            if (turn_cycles == 0) begin
              state_q    <= ST_TX;
              tx_ready_q <= 1'b1;
            end else begin
              state_q <= ST_TURN_TX;
              cnt_q   <= TURN_LOAD;
            end
          end
        end
        ST_TURN_TX: begin
          oe_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q    <= ST_TX;
            tx_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_TX: begin
          if (tx_valid) begin
            out_q <= tx_data;
            oe_q  <= 1'b1;
          end else begin
            // Release now: the last word was on the bus during this cycle.
            oe_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            if (turn_cycles == 0) begin
              state_q <= ST_RX;
            end else begin
              state_q <= ST_TURN_RX;
              cnt_q   <= TURN_LOAD;
            end
          end
        end
        ST_TURN_RX: begin
          oe_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= ST_RX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q    <= ST_RX;
          cnt_q      <= '0;
          oe_q       <= 1'b0;
          tx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign bus_dir  = oe_q;

endmodule : inout_bus_ctrl
